sram_ctrl: RTL and testbench
============================

# sram_ctrl

Parametrised, clocked controller for the asynchronous SRAM that backs the framebuffer. It generalises the bare WE/OE/ADDR/DATA SRAM model into a synchronous two-port front end. The scanout read port has priority over the drawing write port, with a bounded starvation guarantee for writes. The controller owns the bidirectional data bus, inserts programmable wait states, and enforces bus turnaround and write hold.

## Interface
Parameters:
- ADDR_W, 16, SRAM address width
- DATA_W, 16, SRAM data width
- WAIT_STATES, 1, extra cycles an access strobe is held; legal range 0..15
- STARVE_LIMIT, 4, maximum consecutive read grants while wr_req is pending; must be ≥1

Ports (one clock; reset is asynchronous and active-low):
- clk50mhz  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  read request, level, held until rd_ack
- rd_addr  in  ADDR_W  read address, sampled on the grant edge
- rd_ack  out  1  one-cycle pulse: read granted, address taken
- rd_data  out  DATA_W  read data, valid while rd_valid
- rd_valid  out  1  one-cycle pulse: rd_data holds the result
- wr_req  in  1  write request, level, held until wr_ack
- wr_addr  in  ADDR_W  write address, sampled on the grant edge
- wr_data  in  DATA_W  write data, sampled on the grant edge
- wr_ack  out  1  one-cycle pulse: write granted, address and data taken
- sram_addr  out  ADDR_W  SRAM address
- sram_we_n  out  1  SRAM write enable, active-low
- sram_oe_n  out  1  SRAM output enable, active-low
- sram_data  inout  DATA_W  SRAM data bus; driven only in WRITE and WHOLD, otherwise Z

## Operation
- **Reset values:** sram_we_n=1, sram_oe_n=1, sram_data=Z, sram_addr=0, rd_ack=0, wr_ack=0, rd_valid=0, rd_data=0, state IDLE, wait counter 0, streak counter 0.
- **FSM states:** IDLE, READ, TURN, WRITE, WHOLD.
- **IDLE arbitration** is evaluated on every IDLE edge:
  - A read wins if rd_req=1 and (wr_req=0 or streak<STARVE_LIMIT).
  - Otherwise a write wins if wr_req=1.
  - Otherwise the FSM stays in IDLE.
- **Read grant:** register rd_addr into sram_addr, set sram_oe_n=0, pulse rd_ack, load the wait counter with WAIT_STATES, enter READ.
- **READ:** decrement the wait counter each edge. On the edge where it is 0:
  - capture sram_data into rd_data, pulse rd_valid, set sram_oe_n=1;
  - go to TURN if wr_req=1 and the write wins next arbitration, else to IDLE.
- **TURN:** one cycle with oe_n=1, we_n=1 and the bus at Z; then IDLE.
- **Write grant:** register wr_addr and wr_data, drive sram_data, set sram_we_n=0, pulse wr_ack, load the wait counter, enter WRITE.
  - If the previous state was READ, the grant occurs only after TURN.
- **WRITE:** on the edge where the counter is 0, set sram_we_n=1 and go to WHOLD. Address and data stay unchanged.
- **WHOLD:** address and data held one more cycle. Then release the bus to Z and go to IDLE.
- **Streak counter:**
  - increments on each read grant while wr_req=1;
  - clears on a write grant or when wr_req=0;
  - saturates at STARVE_LIMIT.
- **Invariants:** sram_oe_n=0 and bus-driven are never true in the same cycle; we_n and oe_n are never both 0.
- **Reset mid-access:** the access is abandoned immediately. No rd_valid and no further ack are issued. The bus is released asynchronously.
- **Simultaneous requests:** both rd_req and wr_req high with streak<STARVE_LIMIT gives the read.

## Timing
- **Read:**
  - rd_ack is high in the cycle after the grant edge.
  - rd_valid is high WAIT_STATES+1 cycles after rd_ack.
  - Read throughput: one read per WAIT_STATES+2 cycles, including the IDLE cycle.
- **Write:**
  - sram_we_n is low for exactly WAIT_STATES+1 cycles.
  - Total write occupancy is WAIT_STATES+3 cycles (WRITE + WHOLD + IDLE).
- **Read followed by write:** adds exactly one TURN cycle.
- **Worst-case write wait** with continuous reads: STARVE_LIMIT×(WAIT_STATES+2) + 1 cycles before wr_ack.
- **Requesters:** may keep req high after ack for back-to-back accesses. The address must be stable only on the grant edge.

## Structure
- Package sram_ctrl_pkg holds:
  - the state enum (IDLE, READ, TURN, WRITE, WHOLD);
  - the wait-counter width constant (4 bits).
- Sub-module sram_arbiter holds the priority decision and the streak counter. Inputs: rd_req, wr_req, grant strobes. Outputs: grant_rd, grant_wr.
- Tristate: a single continuous assign in sram_ctrl driven by the registered drive-enable.

## Test plan
- **Reset:** hold rst_n=0, toggle requests → all outputs at reset values and sram_data=Z. Deassert rst_n → IDLE, no acks.
- **Single read, WAIT_STATES=1:** preload SRAM model word 0x0010=0xBEEF, pulse rd_req with rd_addr=0x0010 → rd_ack one cycle, sram_oe_n low 2 cycles, rd_valid with rd_data=0xBEEF 2 cycles after rd_ack.
- **Single write, WAIT_STATES=0:** wr_addr=0x0020, wr_data=0x1234 → sram_we_n low 1 cycle, data held through WHOLD, model word 0x0020=0x1234, bus Z afterwards.
- **Read then write:** both requested at once → read first, one TURN cycle with oe_n=1 and bus Z, then wr_ack. Assert no cycle has oe_n=0 while the bus is driven.
- **Starvation, STARVE_LIMIT=4:** rd_req held continuously and wr_req held high → exactly 4 rd_acks, then wr_ack, then reads resume.
- **Reset mid-write:** assert rst_n low during WRITE with WAIT_STATES=3 → we_n=1 and bus Z within the same cycle, no wr_ack or rd_valid afterwards.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the framebuffer SRAM controller: FSM state encoding and
// the wait-state counter width.
`timescale 1ns/1ps
package sram_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, READ, TURN, WRITE, WHOLD} state_t;
    localparam int WAIT_W = 4;
endpackage

// File: rtl/sram_arbiter.sv
// Read-priority arbiter with a saturating streak counter that bounds how many
// reads may be granted back to back while a write is waiting.
`timescale 1ns/1ps
module sram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk50mhz,
    input  logic rst_n,
    input  logic rd_req,
    input  logic wr_req,
    input  logic rd_grant_stb,
    input  logic wr_grant_stb,
    output logic grant_rd,
    output logic grant_wr
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak_reg, streak_next;

    assign grant_rd = rd_req && (!wr_req || (streak_reg < LIMIT));
    assign grant_wr = wr_req && !grant_rd;

    always_comb begin
        streak_next = streak_reg;
        if (!wr_req || wr_grant_stb) begin
            streak_next = '0;
        end else if (rd_grant_stb && (streak_reg < LIMIT)) begin
            streak_next = streak_reg + SW'(1);
        end
    end

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end
endmodule

// File: rtl/sram_ctrl.sv
// Synchronous two-port front end for the asynchronous framebuffer SRAM:
// scanout reads win over drawing writes, with wait states, turnaround and write hold.
`timescale 1ns/1ps
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk50mhz,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    inout  wire  [DATA_W-1:0] sram_data
);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic drive_en_reg, drive_en_next;
    logic we_n_reg, we_n_next, oe_n_reg, oe_n_next;
    logic rd_ack_reg, rd_ack_next, wr_ack_reg, wr_ack_next;
    logic rd_valid_reg, rd_valid_next;
    logic grant_rd, grant_wr, take_rd, take_wr, wait_done;

    assign wait_done = (wait_reg == '0);

    sram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arbiter (
        .clk50mhz     (clk50mhz),
        .rst_n        (rst_n),
        .rd_req       (rd_req),
        .wr_req       (wr_req),
        .rd_grant_stb (take_rd),
        .wr_grant_stb (take_wr),
        .grant_rd     (grant_rd),
        .grant_wr     (grant_wr)
    );

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Leaving READ towards a pending write detours through TURN so the SRAM
    // output driver is off for a full cycle before the controller drives.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_rd) state_next = READ;
                     else if (grant_wr) state_next = WRITE;
            READ:    if (wait_done) state_next = grant_wr ? TURN : IDLE;
            TURN:    state_next = IDLE;
            WRITE:   if (wait_done) state_next = WHOLD;
            WHOLD:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wait_next     = wait_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        drive_en_next = drive_en_reg;
        we_n_next     = we_n_reg;
        oe_n_next     = oe_n_reg;
        rd_ack_next   = 1'b0;
        wr_ack_next   = 1'b0;
        rd_valid_next = 1'b0;
        take_rd       = 1'b0;
        take_wr       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_rd) begin
                    take_rd     = 1'b1;
                    addr_next   = rd_addr;
                    oe_n_next   = 1'b0;
                    rd_ack_next = 1'b1;
                    wait_next   = WAIT_LOAD;
                end else if (grant_wr) begin
                    take_wr       = 1'b1;
                    addr_next     = wr_addr;
                    wdata_next    = wr_data;
                    drive_en_next = 1'b1;
                    we_n_next     = 1'b0;
                    wr_ack_next   = 1'b1;
                    wait_next     = WAIT_LOAD;
                end
            end
            READ: begin
                if (wait_done) begin
                    rdata_next    = sram_data;
                    rd_valid_next = 1'b1;
                    oe_n_next     = 1'b1;
                end else begin
                    wait_next = wait_reg - WAIT_W'(1);
                end
            end
            WRITE: begin
                if (wait_done) begin
                    we_n_next = 1'b1;
                end else begin
                    wait_next = wait_reg - WAIT_W'(1);
                end
            end
            WHOLD:   drive_en_next = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            wait_reg     <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            drive_en_reg <= 1'b0;
            we_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            rd_ack_reg   <= 1'b0;
            wr_ack_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            wait_reg     <= wait_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            drive_en_reg <= drive_en_next;
            we_n_reg     <= we_n_next;
            oe_n_reg     <= oe_n_next;
            rd_ack_reg   <= rd_ack_next;
            wr_ack_reg   <= wr_ack_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    assign sram_addr = addr_reg;
    assign sram_we_n = we_n_reg;
    assign sram_oe_n = oe_n_reg;
    assign rd_ack    = rd_ack_reg;
    assign wr_ack    = wr_ack_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rdata_reg;
    assign sram_data = drive_en_reg ? wdata_reg : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM array model, transaction scoreboard and timing
// rules checked against directed and randomized requester traffic.
`timescale 1ns/1ps
module tb_sram_ctrl;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int WS  = 1;
    localparam int LIM = 4;

    logic clk50mhz = 1'b0;
    logic rst_n    = 1'b1;
    logic rd_req   = 1'b0;
    logic wr_req   = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    wire           rd_ack, rd_valid, wr_ack, sram_we_n, sram_oe_n;
    wire  [DW-1:0] rd_data;
    wire  [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #10 clk50mhz = ~clk50mhz;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .STARVE_LIMIT(LIM)) dut (
        .clk50mhz (clk50mhz), .rst_n (rst_n),
        .rd_req (rd_req), .rd_addr (rd_addr), .rd_ack (rd_ack),
        .rd_data (rd_data), .rd_valid (rd_valid),
        .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_ack (wr_ack),
        .sram_addr (sram_addr), .sram_we_n (sram_we_n), .sram_oe_n (sram_oe_n),
        .sram_data (sram_data)
    );

    // Asynchronous SRAM: drives the bus while OE is active, stores while WE is low.
    assign sram_data = (!sram_oe_n && sram_we_n) ? mem[sram_addr] : {DW{1'bz}};
    wire drv = dut.drive_en_reg;

    always @(negedge clk50mhz) begin
        if (rst_n && !sram_we_n) mem[sram_addr] = sram_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: read data from the model memory, read latency, write landing,
    // we_n pulse width, bus-safety invariants and the starvation bound.
    int            rd_q_cyc[$];
    logic [DW-1:0] rd_q_exp[$];
    logic          pend_w = 1'b0;
    logic [AW-1:0] pend_a = '0;
    logic [DW-1:0] pend_d = '0;
    logic          drv_q = 1'b0;
    logic          wr_req_q = 1'b0;
    int            we_low = 0;
    int            streak = 0;

    always @(negedge clk50mhz) begin
        cyc++;
        if (!rst_n) begin
            rd_q_cyc.delete();
            rd_q_exp.delete();
            pend_w = 1'b0;
            we_low = 0;
            streak = 0;
        end else begin
            check("oe_with_drive", 32'(!sram_oe_n && drv), 0);
            check("oe_with_we", 32'(!sram_oe_n && !sram_we_n), 0);
            if (rd_ack) begin
                rd_q_cyc.push_back(cyc);
                rd_q_exp.push_back(ref_mem[rd_addr]);
            end
            if (rd_valid) begin
                if (rd_q_cyc.size() == 0) begin
                    check("rd_valid_unexpected", 1, 0);
                end else begin
                    int c;
                    logic [DW-1:0] e;
                    c = rd_q_cyc.pop_front();
                    e = rd_q_exp.pop_front();
                    check("rd_latency", 32'(cyc - c), WS + 1);
                    check("rd_data", 32'(rd_data), 32'(e));
                end
            end
            if (wr_ack) begin
                pend_w = 1'b1;
                pend_a = wr_addr;
                pend_d = wr_data;
            end
            if (drv && pend_w) check("bus_wdata", 32'(sram_data), 32'(pend_d));
            if (drv_q && !drv && pend_w) begin
                check("sram_word", 32'(mem[pend_a]), 32'(pend_d));
                ref_mem[pend_a] = pend_d;
                pend_w = 1'b0;
            end
            if (!sram_we_n) begin
                we_low++;
            end else if (we_low != 0) begin
                check("we_low_cycles", 32'(we_low), WS + 1);
                we_low = 0;
            end
            if (wr_ack || !wr_req_q) begin
                streak = 0;
            end else if (rd_ack) begin
                streak++;
                check("streak_bound", 32'(streak > LIM), 0);
            end
        end
        drv_q    = drv;
        wr_req_q = wr_req;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic rd_requester(input int count);
        for (int i = 0; i < count; i++) begin
            int t = 0;
            @(posedge clk50mhz); #2;
            rd_addr = AW'($urandom_range(0, 15));
            rd_req  = 1'b1;
            do begin @(negedge clk50mhz); t++; end while (!rd_ack && t < 200);
            check("rd_ack_seen", 32'(rd_ack), 1);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk50mhz); #2;
                rd_req = 1'b0;
                repeat ($urandom_range(0, 4)) @(posedge clk50mhz);
            end
        end
        @(posedge clk50mhz); #2;
        rd_req = 1'b0;
    endtask

    task automatic wr_requester(input int count);
        for (int i = 0; i < count; i++) begin
            int t = 0;
            @(posedge clk50mhz); #2;
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = DW'($urandom);
            wr_req  = 1'b1;
            do begin @(negedge clk50mhz); t++; end while (!wr_ack && t < 200);
            check("wr_ack_seen", 32'(wr_ack), 1);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk50mhz); #2;
                wr_req = 1'b0;
                repeat ($urandom_range(0, 6)) @(posedge clk50mhz);
            end
        end
        @(posedge clk50mhz); #2;
        wr_req = 1'b0;
    endtask

    initial begin
        int ack_n, val_n, wack_n, oe_low, we_cnt, drv_cnt, rd_before, resume_n, n_ev;
        logic [DW-1:0] val_d;
        logic [2:0] snap;

        for (int a = 0; a < 64; a++) begin
            mem[a]     = DW'($urandom);
            ref_mem[a] = mem[a];
        end
        mem[16'h0010]     = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;

        // reset held while requests toggle
        #3 rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk50mhz); #2;
            rd_req  = 1'($urandom);
            wr_req  = 1'($urandom);
            rd_addr = AW'($urandom);
            wr_addr = AW'($urandom);
            @(negedge clk50mhz);
            check("reset_ctrl", 32'({sram_we_n, sram_oe_n, rd_ack, wr_ack, rd_valid, drv}), 32'h30);
            check("reset_addr_data", 32'({sram_addr, rd_data}), 0);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        #2 rst_n = 1'b1;
        n_ev = 0;
        repeat (4) begin
            @(negedge clk50mhz);
            n_ev += int'(rd_ack) + int'(wr_ack) + int'(rd_valid);
        end
        check("post_reset_idle", 32'(n_ev), 0);

        // single read
        @(posedge clk50mhz); #2;
        rd_addr = 16'h0010;
        rd_req  = 1'b1;
        ack_n = 0; val_n = 0; oe_low = 0; val_d = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk50mhz);
            if (!sram_oe_n) oe_low++;
            if (rd_valid) begin val_n = n; val_d = rd_data; end
            if (rd_ack && ack_n == 0) begin ack_n = n; #2 rd_req = 1'b0; end
        end
        check("rd_ack_time", 32'(ack_n), 2);
        check("rd_valid_time", 32'(val_n), 2 + WS + 1);
        check("rd_beef", 32'(val_d), 32'h0000BEEF);
        check("oe_low_cycles", 32'(oe_low), WS + 1);

        // single write
        @(posedge clk50mhz); #2;
        wr_addr = 16'h0020;
        wr_data = 16'h1234;
        wr_req  = 1'b1;
        ack_n = 0; we_cnt = 0; drv_cnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk50mhz);
            if (!sram_we_n) we_cnt++;
            if (drv) drv_cnt++;
            if (wr_ack && ack_n == 0) begin ack_n = n; #2 wr_req = 1'b0; end
        end
        check("wr_ack_time", 32'(ack_n), 2);
        check("wr_we_cycles", 32'(we_cnt), WS + 1);
        check("wr_drive_cycles", 32'(drv_cnt), WS + 2);
        check("wr_mem_0020", 32'(mem[16'h0020]), 32'h1234);
        check("wr_released", 32'({drv, sram_we_n}), 1);

        // simultaneous read and write: read first, turnaround, then write
        @(posedge clk50mhz); #2;
        rd_addr = 16'h0010;
        wr_addr = 16'h0030;
        wr_data = 16'hA5A5;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        ack_n = 0; val_n = 0; wack_n = 0; snap = '0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk50mhz);
            if (rd_valid) begin val_n = n; snap = {sram_oe_n, sram_we_n, drv}; end
            if (wr_ack && wack_n == 0) begin wack_n = n; #2 wr_req = 1'b0; end
            if (rd_ack && ack_n == 0) begin ack_n = n; #2 rd_req = 1'b0; end
        end
        check("rw_rd_ack_time", 32'(ack_n), 2);
        check("rw_rd_valid_time", 32'(val_n), 2 + WS + 1);
        check("rw_turn_idle", 32'(snap), 32'b110);
        check("rw_wr_ack_time", 32'(wack_n), 2 + WS + 1 + 2);
        check("rw_mem_0030", 32'(mem[16'h0030]), 32'hA5A5);

        // starvation bound: both held, reads until the limit, then the write
        @(posedge clk50mhz); #2;
        rd_addr = 16'h0011;
        wr_addr = 16'h0031;
        wr_data = 16'h5A5A;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        rd_before = 0; wack_n = 0; resume_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk50mhz);
            if (rd_ack && wack_n == 0) rd_before++;
            if (rd_ack && wack_n != 0 && resume_n == 0) begin resume_n = n; #2 rd_req = 1'b0; end
            if (wr_ack && wack_n == 0) begin wack_n = n; #2 wr_req = 1'b0; end
        end
        rd_req = 1'b0;
        check("starve_reads", 32'(rd_before), LIM);
        check("starve_wr_time", 32'(wack_n), LIM * (WS + 2) + 3);
        check("starve_resume", 32'(resume_n - wack_n), WS + 3);

        // randomized concurrent traffic
        fork
            rd_requester(40);
            wr_requester(40);
        join
        repeat (20) @(negedge clk50mhz);
        check("rd_outstanding", 32'(rd_q_cyc.size()), 0);

        // reset during a write
        @(posedge clk50mhz); #2;
        wr_addr = 16'h00FF;
        wr_data = 16'hDEAD;
        wr_req  = 1'b1;
        ack_n = 0;
        for (int n = 1; n <= 10 && ack_n == 0; n++) begin
            @(negedge clk50mhz);
            if (wr_ack) ack_n = n;
        end
        check("mid_wr_ack", 32'(ack_n), 2);
        check("mid_wr_we_low", 32'(sram_we_n), 0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_wr_release", 32'({sram_we_n, sram_oe_n, drv}), 32'b110);
        wr_req = 1'b0;
        repeat (3) @(negedge clk50mhz);
        #2 rst_n = 1'b1;
        n_ev = 0;
        repeat (10) begin
            @(negedge clk50mhz);
            n_ev += int'(rd_ack) + int'(wr_ack) + int'(rd_valid);
        end
        check("mid_wr_quiet", 32'(n_ev), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
